wb_master_port: RTL and testbench

// - Wishbone classic (B3) single-transfer bus master; the initiator side for the SoC's WB slaves (ROM, RAM, peripherals).
// - Converts a valid/ready request from the core fetch or LSU into one WB cycle.
// - Returns read data or an error on a valid/ready response channel.
// - One outstanding transfer, with a single-entry response buffer.

---
 rtl/wb_master_port.sv | 160 ++++++++++++++++
 tb/tb_wb_master_port.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wb_master_port.sv
// Wishbone classic (B3) single-transfer bus master: one valid/ready request becomes one WB cycle,
// answered on a single-entry valid/ready response buffer. Define WB_TIMEOUT_EN to add a cycle timeout.
module wb_master_port #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [AW-1:0]   req_addr_i,
  input  logic            req_we_i,
  input  logic [DW/8-1:0] req_sel_i,
  input  logic [DW-1:0]   req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic            rsp_err_o,
  output logic            cyc_o,
  output logic            stb_o,
  output logic [AW-1:0]   adr_o,
  output logic            we_o,
  output logic [DW/8-1:0] sel_o,
  output logic [DW-1:0]   dat_o,
  input  logic [DW-1:0]   dat_i,
  input  logic            ack_i,
  input  logic            err_i
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;

  state_e            state_q, state_d;
  logic              cyc_q, cyc_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic              we_q, we_d;
  logic [DW/8-1:0]   sel_q, sel_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  // Word-aligned bus: the byte offset bits never reach the slave.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr_i[1:0];

`ifdef WB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`else
  localparam int unsigned UNUSED_TMO = TIMEOUT_CYCLES;
`endif

  // Held low during reset so the core never sees a ready before release.
  assign req_ready_o = (state_q == S_IDLE) && !rst_i;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    adr_d       = adr_q;
    we_d        = we_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef WB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d = S_BUS;
          cyc_d   = 1'b1;
          adr_d   = {req_addr_i[AW-1:2], 2'b00};
          we_d    = req_we_i;
          sel_d   = req_sel_i;
          dat_d   = req_wdata_i;
`ifdef WB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      S_BUS: begin
        if (ack_i || err_i) begin
          // Error wins over a simultaneous ack; write responses carry no data.
          state_d     = S_RESP;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_i;
          rsp_rdata_d = (ack_i && !err_i && !we_q) ? dat_i : '0;
        end
`ifdef WB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          state_d     = S_RESP;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      adr_q       <= '0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef WB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      adr_q       <= adr_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef WB_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign cyc_o       = cyc_q;
  assign stb_o       = cyc_q;
  assign adr_o       = adr_q;
  assign we_o        = we_q;
  assign sel_o       = sel_q;
  assign dat_o       = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_master_port.sv
// Directed bench for wb_master_port: read, write, backpressure, error, timeout/hang and async reset.
module tb_wb_master_port;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [AW-1:0]   req_addr_i;
  logic            req_we_i;
  logic [DW/8-1:0] req_sel_i;
  logic [DW-1:0]   req_wdata_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [DW-1:0]   rsp_rdata_o;
  logic            rsp_err_o;
  logic            cyc_o, stb_o;
  logic [AW-1:0]   adr_o;
  logic            we_o;
  logic [DW/8-1:0] sel_o;
  logic [DW-1:0]   dat_o;
  logic [DW-1:0]   dat_i;
  logic            ack_i, err_i;

  int total = 0;
  int bad   = 0;

  wb_master_port #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_sel_i(req_sel_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o), .we_o(we_o),
    .sel_o(sel_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Issues one request, plays a slave that terminates after wait_st wait states,
  // and returns the number of cycles cyc_o was seen high (bounded by max_cyc).
  task automatic xfer(input string tag, input logic [31:0] addr, input logic we,
                      input logic [3:0] sel, input logic [31:0] wdata, input logic [31:0] rdata,
                      input int wait_st, input logic t_ack, input logic t_err,
                      input int max_cyc, output int cyc_cnt);
    logic ok;
    ok = 1'b1;
    @(negedge clk_i);
    chk({tag, "_req_ready"}, req_ready_o, 1'b1);
    req_valid_i = 1'b1; req_addr_i = addr; req_we_i = we; req_sel_i = sel; req_wdata_i = wdata;
    @(negedge clk_i);
    req_valid_i = 1'b0; req_addr_i = 32'hFFFF_FFFF; req_wdata_i = 32'h0; req_sel_i = 4'h0;
    cyc_cnt = 0;
    for (int i = 0; i < max_cyc && cyc_o; i++) begin
      cyc_cnt++;
      if (stb_o !== 1'b1 || adr_o !== {addr[31:2], 2'b00} || we_o !== we ||
          sel_o !== sel || dat_o !== wdata || rsp_valid_o !== 1'b0)
        ok = 1'b0;
      if (cyc_cnt == wait_st + 1) begin
        ack_i = t_ack; err_i = t_err; dat_i = rdata;
      end else begin
        ack_i = 1'b0; err_i = 1'b0; dat_i = 32'hBAD0_BAD0;
      end
      @(negedge clk_i);
    end
    ack_i = 1'b0; err_i = 1'b0;
    chk({tag, "_bus_stable"}, ok, 1'b1);
  endtask

  task automatic handshake(input string tag);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk({tag, "_rsp_drop"}, rsp_valid_o, 1'b0);
    chk({tag, "_idle_ready"}, req_ready_o, 1'b1);
  endtask

  int  n;
  logic hold_ok;
  logic [31:0] held;

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_we_i = 1'b0; req_sel_i = '0;
    req_wdata_i = '0; rsp_ready_i = 1'b0; dat_i = '0; ack_i = 1'b0; err_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_outputs", {req_ready_o, rsp_valid_o, rsp_err_o, cyc_o, stb_o, we_o}, 6'b0);
    chk("rst_buses", {adr_o, dat_o}, 64'h0);
    chk("rst_rdata", rsp_rdata_o, 32'h0);
    rst_i = 1'b0;
    #1 chk("rst_release_ready", req_ready_o, 1'b1);

    // ROM read, one wait state
    xfer("rd", 32'h13, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1, 1'b1, 1'b0, 50, n);
    chk("rd_cyc_len", n, 2);
    chk("rd_valid", {rsp_valid_o, cyc_o, req_ready_o}, 3'b100);
    chk("rd_data", rsp_rdata_o, 32'hDEAD_BEEF);
    chk("rd_err", rsp_err_o, 1'b0);
    handshake("rd");

    // Write: response data must be zero even if the slave drives junk
    xfer("wr", 32'h20, 1'b1, 4'b0011, 32'h1234_ABCD, 32'hFFFF_FFFF, 1, 1'b1, 1'b0, 50, n);
    chk("wr_cyc_len", n, 2);
    chk("wr_valid_err", {rsp_valid_o, rsp_err_o, we_o}, 3'b100);
    chk("wr_rdata", rsp_rdata_o, 32'h0);
    handshake("wr");

    // Backpressure with zero-wait slave; stray ack and new request must be ignored
    xfer("bp", 32'h44, 1'b0, 4'hF, 32'h0, 32'hCAFE_0001, 0, 1'b1, 1'b0, 50, n);
    chk("bp_cyc_len", n, 1);
    held = rsp_rdata_o;
    chk("bp_data", held, 32'hCAFE_0001);
    hold_ok = 1'b1;
    req_valid_i = 1'b1; req_addr_i = 32'h80; req_we_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ack_i = i[0]; err_i = i[1];
      @(negedge clk_i);
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hCAFE_0001 || rsp_err_o !== 1'b0 ||
          req_ready_o !== 1'b0 || cyc_o !== 1'b0)
        hold_ok = 1'b0;
    end
    ack_i = 1'b0; err_i = 1'b0; req_valid_i = 1'b0;
    chk("bp_hold", hold_ok, 1'b1);
    handshake("bp");

    // Error termination, then ack+err together
    xfer("er", 32'h100, 1'b0, 4'hF, 32'h0, 32'h5555_5555, 2, 1'b0, 1'b1, 50, n);
    chk("er_cyc_len", n, 3);
    chk("er_flags", {rsp_valid_o, rsp_err_o}, 2'b11);
    chk("er_rdata", rsp_rdata_o, 32'h0);
    handshake("er");
    xfer("ae", 32'h104, 1'b0, 4'hF, 32'h0, 32'h7777_7777, 1, 1'b1, 1'b1, 50, n);
    chk("ae_flags", {rsp_valid_o, rsp_err_o}, 2'b11);
    chk("ae_rdata", rsp_rdata_o, 32'h0);
    handshake("ae");

    // Silent slave
`ifdef WB_TIMEOUT_EN
    xfer("to", 32'h200, 1'b0, 4'hF, 32'h0, 32'h0, 1000, 1'b0, 1'b0, 100, n);
    chk("to_cyc_len", n, TMO);
    chk("to_flags", {cyc_o, rsp_valid_o, rsp_err_o}, 3'b011);
    chk("to_rdata", rsp_rdata_o, 32'h0);
    handshake("to");
    xfer("hang", 32'h204, 1'b0, 4'hF, 32'h0, 32'h0, 1000, 1'b0, 1'b0, 3, n);
`else
    xfer("hang", 32'h200, 1'b0, 4'hF, 32'h0, 32'h0, 1000, 1'b0, 1'b0, 100, n);
    chk("hang_cyc_len", n, 100);
`endif
    chk("hang_still_bus", {cyc_o, stb_o, rsp_valid_o}, 3'b110);

    // Asynchronous reset between clock edges
    #2 rst_i = 1'b1;
    #1 chk("arst_drop", {cyc_o, stb_o, rsp_valid_o, req_ready_o}, 4'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1 chk("arst_ready", req_ready_o, 1'b1);
    xfer("post", 32'h13, 1'b0, 4'hF, 32'h0, 32'h0BAD_F00D, 1, 1'b1, 1'b0, 50, n);
    chk("post_cyc_len", n, 2);
    chk("post_data", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, {2'b10, 32'h0BAD_F00D});
    handshake("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
